// File: rtl/md_sched_if.sv
// ---------------------------------------------------------------------------
// md_sched_if -- EX/ID-side bus of the multiply/divide scheduler.
//
//   E_start   EX stage holds a valid MD instruction this cycle
//   E_md_op   MD operation code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mthi, 6 mtlo, 7 reserved)
//   E_A/E_B   forwarded rs / rt operands
//   D_md_use  ID stage holds any MD instruction
//   busy      operation in flight
//   stall     stall request to ID/PC (combinational)
//   done      one-cycle pulse after a mult/div commit
//   HI/LO     architectural HI/LO registers
//
// master: pipeline side (drives the EX/ID signals).
// slave:  the scheduler.
// ---------------------------------------------------------------------------
interface md_sched_if;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md_use;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_md_op, E_A, E_B, D_md_use,
    input  busy, stall, done, HI, LO
  );

  modport slave (
    input  E_start, E_md_op, E_A, E_B, D_md_use,
    output busy, stall, done, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- multiply/divide scheduler for the five-stage MIPS pipeline.
//
// Accepts mult/multu/div/divu/mthi/mtlo from EX, owns HI/LO and models the
// MD unit latency with a down-counter. The full result is computed in the
// issue cycle and parked in a pending register; it becomes architecturally
// visible only when the latency window closes.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    md_sched_if.slave (EX operands, ID usage, busy/stall/done, HI/LO)
//
// Parameters:
//   MULT_LAT  busy cycles for mult/multu (>= 1)
//   DIV_LAT   busy cycles for div/divu   (>= 1)
// ---------------------------------------------------------------------------
module md_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_sched_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             commit_q, commit_d;   // 0 for divide-by-zero: keep HI/LO
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // ---- Datapath: results for every op, selected at issue ----
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag_safe, b_u_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{bus.E_A[31]}}, bus.E_A} * {{32{bus.E_B[31]}}, bus.E_B};
  assign prod_u = {32'd0, bus.E_A} * {32'd0, bus.E_B};

  // Signed divide done on magnitudes so 0x80000000 / -1 needs no special
  // case (its magnitude fits in 32 unsigned bits) and truncates toward zero.
  // A zero divisor is replaced by 1 only to keep the divider well defined;
  // that result is never committed.
  assign a_neg      = bus.E_A[31];
  assign b_neg      = bus.E_B[31];
  assign b_zero     = (bus.E_B == 32'd0);
  assign a_mag      = a_neg ? (~bus.E_A + 32'd1) : bus.E_A;
  assign b_mag_safe = b_zero ? 32'd1 : (b_neg ? (~bus.E_B + 32'd1) : bus.E_B);
  assign b_u_safe   = b_zero ? 32'd1 : bus.E_B;

  assign q_mag = a_mag / b_mag_safe;
  assign r_mag = a_mag % b_mag_safe;
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = bus.E_A / b_u_safe;
  assign r_u   = bus.E_A % b_u_safe;

  // ---- Next-state logic ----
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    commit_d  = commit_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.E_start) begin
          case (bus.E_md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              commit_d = 1'b1;
              cnt_d    = MULT_LOAD;
              state_d  = ST_RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              commit_d = 1'b1;
              cnt_d    = MULT_LOAD;
              state_d  = ST_RUN;
            end
            OP_DIV: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              commit_d  = ~b_zero;
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            OP_DIVU: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              commit_d  = ~b_zero;
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = bus.E_A;
            OP_MTLO: lo_d = bus.E_A;
            default: ;  // none / reserved
          endcase
        end
      end

      default: begin  // ST_RUN: new starts are ignored here
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // ---- State registers ----
  // NOTE: non-blocking assignments so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      commit_q  <= 1'b0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      commit_q  <= commit_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // ---- Outputs ----
  logic issue_md;
  assign issue_md = bus.E_start && (bus.E_md_op >= OP_MULT) && (bus.E_md_op <= OP_DIVU);

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = done_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  // Hold a decode-stage MD instruction while an operation is in flight or
  // being issued, so mfhi/mflo never read a stale HI/LO.
  assign bus.stall = bus.D_md_use & (bus.busy | issue_md);

endmodule

// File: tb/tb_md_sched.sv
// ---------------------------------------------------------------------------
// tb_md_sched -- directed self-checking bench for md_sched
// (MULT_LAT = 5, DIV_LAT = 10).
// ---------------------------------------------------------------------------
module tb_md_sched;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  md_sched_if bus ();

  md_sched #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an operation: start is high for the one posedge after the next
  // negedge; returns at the following negedge (first cycle after issue).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.E_start = 1'b1;
    bus.E_md_op = op;
    bus.E_A     = a;
    bus.E_B     = b;
    @(negedge clk);
    bus.E_start = 1'b0;
    bus.E_md_op = 3'd0;
    #1;
  endtask

  // Count busy cycles until busy falls (bounded); ends in the done cycle.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int n;
    issue(3'd5, 32'hAAAA_5555, 32'd0);          // HI nonzero before reset
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_async_busy got=%b exp=0", bus.busy); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.D_md_use = 1'b1;
    #1;
    n_total++; if (bus.busy  !== 1'b0)  $display("FAIL reset_busy got=%b exp=0", bus.busy);   else n_pass++;
    n_total++; if (bus.done  !== 1'b0)  $display("FAIL reset_done got=%b exp=0", bus.done);   else n_pass++;
    n_total++; if (bus.HI    !== 32'd0) $display("FAIL reset_hi got=%h exp=0", bus.HI);       else n_pass++;
    n_total++; if (bus.LO    !== 32'd0) $display("FAIL reset_lo got=%h exp=0", bus.LO);       else n_pass++;
    n_total++; if (bus.stall !== 1'b0)  $display("FAIL reset_stall got=%b exp=0", bus.stall); else n_pass++;
    bus.D_md_use = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    n = (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0) ? 1 : 0;
    n_total++; if (n != 0) $display("FAIL reset_abandon got=hi:%h lo:%h busy:%b exp=0/0/0", bus.HI, bus.LO, bus.busy); else n_pass++;
  endtask

  task automatic test_mult();
    int n;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    n_total++; if (n != MULT_LAT)             $display("FAIL mult_busy got=%0d exp=%0d", n, MULT_LAT);  else n_pass++;
    n_total++; if (bus.done !== 1'b1)         $display("FAIL mult_done got=%b exp=1", bus.done);        else n_pass++;
    n_total++; if (bus.HI !== 32'hFFFF_FFFF)  $display("FAIL mult_hi got=%h exp=ffffffff", bus.HI);     else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFA)  $display("FAIL mult_lo got=%h exp=fffffffa", bus.LO);     else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bus.done !== 1'b0)         $display("FAIL mult_done_pulse got=%b exp=0", bus.done);  else n_pass++;

    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    n_total++; if (n != MULT_LAT)             $display("FAIL multu_busy got=%0d exp=%0d", n, MULT_LAT); else n_pass++;
    n_total++; if (bus.HI !== 32'h0000_0002)  $display("FAIL multu_hi got=%h exp=00000002", bus.HI);    else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFA)  $display("FAIL multu_lo got=%h exp=fffffffa", bus.LO);    else n_pass++;
  endtask

  task automatic test_div();
    int n;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);          // -7 / 2
    wait_idle(n);
    n_total++; if (n != DIV_LAT)              $display("FAIL div_busy got=%0d exp=%0d", n, DIV_LAT);    else n_pass++;
    n_total++; if (bus.done !== 1'b1)         $display("FAIL div_done got=%b exp=1", bus.done);         else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFD)  $display("FAIL div_lo got=%h exp=fffffffd", bus.LO);      else n_pass++;
    n_total++; if (bus.HI !== 32'hFFFF_FFFF)  $display("FAIL div_hi got=%h exp=ffffffff", bus.HI);      else n_pass++;

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);  // overflow corner
    wait_idle(n);
    n_total++; if (bus.LO !== 32'h8000_0000)  $display("FAIL div_ovf_lo got=%h exp=80000000", bus.LO);  else n_pass++;
    n_total++; if (bus.HI !== 32'h0000_0000)  $display("FAIL div_ovf_hi got=%h exp=00000000", bus.HI);  else n_pass++;

    issue(3'd4, 32'hFFFF_FFF9, 32'd2);          // divu: 4294967289 / 2
    wait_idle(n);
    n_total++; if (bus.LO !== 32'h7FFF_FFFC)  $display("FAIL divu_lo got=%h exp=7ffffffc", bus.LO);     else n_pass++;
    n_total++; if (bus.HI !== 32'h0000_0001)  $display("FAIL divu_hi got=%h exp=00000001", bus.HI);     else n_pass++;
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'd5, 32'h0000_0011, 32'd0);
    issue(3'd6, 32'h0000_0022, 32'd0);
    issue(3'd4, 32'd5, 32'd0);
    wait_idle(n);
    n_total++; if (n != DIV_LAT)              $display("FAIL divz_busy got=%0d exp=%0d", n, DIV_LAT);   else n_pass++;
    n_total++; if (bus.done !== 1'b1)         $display("FAIL divz_done got=%b exp=1", bus.done);        else n_pass++;
    n_total++; if (bus.HI !== 32'h0000_0011)  $display("FAIL divz_hi got=%h exp=00000011", bus.HI);     else n_pass++;
    n_total++; if (bus.LO !== 32'h0000_0022)  $display("FAIL divz_lo got=%h exp=00000022", bus.LO);     else n_pass++;
  endtask

  task automatic test_stall_back_to_back();
    int   n;
    logic bad;
    bus.D_md_use = 1'b1;
    @(negedge clk);
    bus.E_start = 1'b1; bus.E_md_op = 3'd1; bus.E_A = 32'd7; bus.E_B = 32'd6;
    #1;
    n_total++; if (bus.stall !== 1'b1) $display("FAIL stall_issue got=%b exp=1", bus.stall); else n_pass++;
    @(negedge clk);
    bus.E_start = 1'b0; bus.E_md_op = 3'd0;
    #1;
    n = 0; bad = 1'b0;
    while (bus.busy === 1'b1 && n < 64) begin
      if (bus.stall !== 1'b1) bad = 1'b1;
      n++;
      @(negedge clk);
      #1;
    end
    n_total++; if (bad !== 1'b0)       $display("FAIL stall_busy got=dropped exp=held"); else n_pass++;
    n_total++; if (n != MULT_LAT)      $display("FAIL stall_len got=%0d exp=%0d", n, MULT_LAT); else n_pass++;
    n_total++; if (bus.stall !== 1'b0) $display("FAIL stall_done_cycle got=%b exp=0", bus.stall); else n_pass++;
    n_total++; if (bus.LO !== 32'd42)  $display("FAIL stall_lo got=%h exp=0000002a", bus.LO); else n_pass++;
    // Back-to-back issue in the done cycle.
    bus.E_start = 1'b1; bus.E_md_op = 3'd2; bus.E_A = 32'd3; bus.E_B = 32'd4;
    @(negedge clk);
    bus.E_start = 1'b0; bus.E_md_op = 3'd0;
    #1;
    n_total++; if (bus.busy !== 1'b1)  $display("FAIL b2b_busy got=%b exp=1", bus.busy); else n_pass++;
    wait_idle(n);
    n_total++; if (n != MULT_LAT)      $display("FAIL b2b_len got=%0d exp=%0d", n, MULT_LAT); else n_pass++;
    n_total++; if (bus.LO !== 32'd12)  $display("FAIL b2b_lo got=%h exp=0000000c", bus.LO); else n_pass++;
    bus.D_md_use = 1'b0;
  endtask

  task automatic test_mthi_ignore();
    int n;
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    n_total++; if (bus.HI !== 32'hDEAD_BEEF) $display("FAIL mthi_hi got=%h exp=deadbeef", bus.HI); else n_pass++;
    n_total++; if (bus.busy !== 1'b0)        $display("FAIL mthi_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0)        $display("FAIL mthi_done got=%b exp=0", bus.done); else n_pass++;
    // Reserved op: no effect.
    issue(3'd7, 32'h1234_5678, 32'd1);
    n_total++; if (bus.busy !== 1'b0 || bus.HI !== 32'hDEAD_BEEF) $display("FAIL op7 got=busy:%b hi:%h exp=0/deadbeef", bus.busy, bus.HI); else n_pass++;
    // Start while busy is ignored.
    issue(3'd1, 32'd2, 32'd3);                  // now in busy cycle 1
    @(negedge clk);                             // busy cycle 2
    bus.E_start = 1'b1; bus.E_md_op = 3'd3; bus.E_A = 32'd100; bus.E_B = 32'd7;
    @(negedge clk);                             // busy cycle 3
    bus.E_start = 1'b0; bus.E_md_op = 3'd0;
    #1;
    wait_idle(n);
    n_total++; if (n != MULT_LAT - 2)   $display("FAIL ign_len got=%0d exp=%0d", n, MULT_LAT - 2); else n_pass++;
    n_total++; if (bus.LO !== 32'd6)    $display("FAIL ign_lo got=%h exp=00000006", bus.LO); else n_pass++;
    n_total++; if (bus.HI !== 32'd0)    $display("FAIL ign_hi got=%h exp=00000000", bus.HI); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bus.busy !== 1'b0)   $display("FAIL ign_no_restart got=%b exp=0", bus.busy); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.E_start  = 1'b0;
    bus.E_md_op  = 3'd0;
    bus.E_A      = 32'd0;
    bus.E_B      = 32'd0;
    bus.D_md_use = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall_back_to_back();
    test_mthi_ignore();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
